// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and types for the continuous monitoring system.
// The snapshot streamer takes its default sizing and its FSM state type from here.
package continuous_monitoring_system_pkg;

    localparam int NO_OF_PERFORMANCE_EVENTS            = 8;
    localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 16;

    typedef enum logic {
        SNAP_IDLE,
        SNAP_STREAM
    } snap_state_e;

    // Index width for a stream of n beats, never narrower than one bit.
    function automatic int snap_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/performance_counter_snapshot.sv
// Captures all performance counters on request and streams per-counter deltas
// since the previous snapshot, one beat per counter, under valid/ready.
module performance_counter_snapshot
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NO_OF_COUNTERS = NO_OF_PERFORMANCE_EVENTS,
    parameter int COUNTER_WIDTH  = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
    localparam int IDX_W         = snap_idx_w(NO_OF_COUNTERS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] counters [NO_OF_COUNTERS],
    input  logic                     snapshot_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic [COUNTER_WIDTH-1:0] out_delta,
    output logic                     out_last,
    output logic                     busy,
    output logic [15:0]              dropped_count
);

    snap_state_e              state, state_nxt;
    logic [IDX_W-1:0]         index;
    logic [COUNTER_WIDTH-1:0] prev  [NO_OF_COUNTERS];
    logic [COUNTER_WIDTH-1:0] delta [NO_OF_COUNTERS];
    logic [15:0]              drop_cnt;

    logic streaming, at_last, handshake, capture, drop;

    assign streaming = (state == SNAP_STREAM);
    assign at_last   = (index == IDX_W'(NO_OF_COUNTERS - 1));
    assign handshake = streaming && out_ready;
    // A request landing on the final handshake chains straight into a new stream.
    assign capture   = snapshot_req && (!streaming || (handshake && at_last));
    assign drop      = snapshot_req && streaming && !(handshake && at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SNAP_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SNAP_IDLE:   if (capture) state_nxt = SNAP_STREAM;
            SNAP_STREAM: if (handshake && at_last && !capture) state_nxt = SNAP_IDLE;
            default:     state_nxt = SNAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
        end else if (capture) begin
            index <= '0;
        end else if (handshake) begin
            index <= at_last ? '0 : index + 1'b1;
        end
    end

    // Modular subtraction absorbs upstream wrap or upstream reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NO_OF_COUNTERS; i++) begin
                prev[i]  <= '0;
                delta[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NO_OF_COUNTERS; i++) begin
                delta[i] <= counters[i] - prev[i];
                prev[i]  <= counters[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign out_valid     = streaming;
    assign busy          = streaming;
    assign out_last      = streaming && at_last;
    assign out_index     = index;
    assign out_delta     = delta[index];
    assign dropped_count = drop_cnt;

endmodule

// File: tb/tb_performance_counter_snapshot.sv
// Directed scoreboard bench for performance_counter_snapshot with 3 x 8-bit counters.
module tb_performance_counter_snapshot;

    localparam int N = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] counters [N];
    logic         snapshot_req;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_index;
    logic [W-1:0] out_delta;
    logic         out_last;
    logic         busy;
    logic [15:0]  dropped_count;

    typedef struct {
        int idx;
        int delta;
        int last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    performance_counter_snapshot #(.NO_OF_COUNTERS(N), .COUNTER_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .counters      (counters),
        .snapshot_req  (snapshot_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .out_delta     (out_delta),
        .out_last      (out_last),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push3(input int d0, input int d1, input int d2);
        q.push_back('{0, d0, 0});
        q.push_back('{1, d1, 0});
        q.push_back('{2, d2, 1});
    endtask

    task automatic set_ctr(input int c0, input int c1, input int c2);
        counters[0] = W'(c0);
        counters[1] = W'(c1);
        counters[2] = W'(c2);
    endtask

    // Raises the request for exactly one capturing edge; returns just after it.
    task automatic do_req();
        @(posedge clk); #1 snapshot_req = 1'b1;
        @(posedge clk); #1 snapshot_req = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        chk("drain_timeout", n < 200, 1);
        chk("busy_after_drain", busy, 0);
        chk("valid_after_drain", out_valid, 0);
    endtask

    // Every presented beat must match the head of the queue, stalled or not.
    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat_index", out_index, -1);
                end else begin
                    e = q[0];
                    chk("beat_index", out_index, e.idx);
                    chk("beat_delta", out_delta, e.delta);
                    chk("beat_last",  out_last,  e.last);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        snapshot_req = 1'b0;
        out_ready = 1'b1;
        set_ctr(0, 0, 0);
        fork
            monitor();
        join_none

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_last",  out_last, 0);
        chk("rst_index", out_index, 0);
        chk("rst_delta", out_delta, 0);
        chk("rst_drop",  dropped_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic stream, ready held high
        set_ctr(5, 0, 2);
        push3(5, 0, 2);
        do_req();
        chk("latency_valid", out_valid, 1);
        chk("latency_index", out_index, 0);
        chk("latency_busy",  busy, 1);
        drain(1'b0);

        // Ready toggling 1,0,1,0 with stalls
        set_ctr(9, 3, 2);
        push3(4, 3, 0);
        do_req();
        drain(1'b1);
        out_ready = 1'b1;

        // Counter wrap: 250 -> 4 is +10 mod 256
        set_ctr(250, 3, 2);
        push3(241, 0, 0);
        do_req();
        drain(1'b0);
        set_ctr(4, 3, 2);
        push3(10, 0, 0);
        do_req();
        drain(1'b0);

        // Two requests while stalled are dropped; live counter changes ignored
        set_ctr(10, 5, 7);
        push3(6, 2, 5);
        out_ready = 1'b0;
        do_req();
        set_ctr(99, 99, 99);
        @(posedge clk); #1 snapshot_req = 1'b1;
        @(posedge clk); #1 snapshot_req = 1'b0;
        @(posedge clk); #1 snapshot_req = 1'b1;
        @(posedge clk); #1 snapshot_req = 1'b0;
        chk("drop_two", dropped_count, 2);
        out_ready = 1'b1;
        drain(1'b0);
        chk("drop_after_stream", dropped_count, 2);

        // Request coincident with final handshake chains without a bubble
        set_ctr(11, 5, 7);
        push3(1, 0, 0);
        push3(9, 1, 0);
        do_req();
        set_ctr(20, 6, 7);
        @(posedge clk); #1;
        @(posedge clk); #1 snapshot_req = 1'b1;
        @(posedge clk); #1 snapshot_req = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_index", out_index, 0);
        drain(1'b0);
        chk("b2b_drop_unchanged", dropped_count, 2);

        // Reset during beat 1 aborts the stream and clears history
        set_ctr(30, 10, 10);
        q.push_back('{0, 10, 0});
        do_req();
        @(posedge clk); #1 out_ready = 1'b0;
        chk("pre_rst_index", out_index, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_drop",  dropped_count, 0);
        chk("mid_rst_queue", q.size(), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        set_ctr(1, 1, 1);
        out_ready = 1'b1;
        push3(1, 1, 1);
        do_req();
        drain(1'b0);

        // Long stall: beat 0 held for 20 cycles
        set_ctr(3, 8, 1);
        push3(2, 7, 0);
        out_ready = 1'b0;
        do_req();
        repeat (20) begin
            @(negedge clk);
            chk("stall_busy",  busy, 1);
            chk("stall_index", out_index, 0);
            chk("stall_delta", out_delta, 2);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain(1'b0);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
